half_adder: RTL and testbench
=============================

Name: half_adder

Overview:
- Registered WIDTH-bit binary adder built from a chain of 1-bit half-adder cells: two half-adders plus an OR gate per bit form a full adder, and the full adders form a ripple-carry chain.
- Produces the sum, carry-out, signed overflow, and bitwise half-adder terms one clock after a valid input.
- Serves as the arithmetic primitive for datapath units that need a registered add with carry-in.

Parameters:
- WIDTH, 20, operand and sum width in bits; legal range is 1 or more.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  qualifies a, b and cin in the current cycle
- a  input  WIDTH  operand A, unsigned or two's complement
- b  input  WIDTH  operand B
- cin  input  1  carry into bit 0
- out_valid  output  1  high for one cycle when the result registers hold a new result
- out  output  WIDTH  registered sum, a+b+cin modulo 2^WIDTH
- cout  output  1  registered carry out of bit WIDTH-1
- ovf  output  1  registered signed overflow
- hsum  output  WIDTH  registered bitwise half-adder sum, a XOR b
- hcarry  output  WIDTH  registered bitwise half-adder carry, a AND b

Behaviour:
- Combinational core:
  - Per bit i: the first half-adder takes a[i] and b[i] and produces p[i] = a^b and g[i] = a&b.
  - The second half-adder takes p[i] and c[i] and produces s[i] and t[i].
  - c[i+1] = g[i] | t[i], with c[0] = cin.
- Arithmetic: {cout, out} = a + b + cin, computed at WIDTH+1 bits with zero extension. There is no saturation; wrap-around is modulo 2^WIDTH.
- Overflow: ovf = c[WIDTH] XOR c[WIDTH-1]. Equivalently, it is set when the operand MSBs are equal and the sum MSB differs from them.
  - When WIDTH = 1, ovf = c[1] XOR cin.
- Reset:
  - While rst is high, regardless of clk: out, hsum and hcarry are all zeros; cout, ovf and out_valid are 0.
  - Reset assertion mid-operation discards any pending result.
  - The first capture after reset release happens on the first rising clk edge with in_valid = 1.
- Capture: on a rising clk edge with in_valid = 1, all result registers load from the combinational core and out_valid is set to 1. Latency is exactly 1 cycle.
- Hold: on a rising clk edge with in_valid = 0, all result registers hold their previous values and out_valid is set to 0.
- Back-to-back: in_valid may be high every cycle. This gives one result per cycle with no bubbles and no backpressure.
- The outputs are driven only from registers; there is no combinational path from inputs to outputs.
- X on a, b or cin while in_valid = 0 must not propagate into the registers.

Test Plan:
- Reset, then a=20'h00000, b=20'hFFFFF, cin=0, in_valid=1 for one cycle -> next cycle: out=20'hFFFFF, cout=0, ovf=0, hsum=20'hFFFFF, hcarry=20'h00000, out_valid=1. The cycle after that: out_valid=0 and out is held at 20'hFFFFF.
- a=20'h00000, b=20'hFFFFF, cin=1 -> out=20'h00000, cout=1, ovf=0. This checks that the carry ripples through all 20 bits.
- a=20'h7FFFF, b=20'h00001, cin=0 -> out=20'h80000, cout=0, ovf=1. Then a=20'h80000, b=20'h80000, cin=0 -> out=20'h00000, cout=1, ovf=1.
- a=20'hAAAAA, b=20'h55555, cin=0 -> out=20'hFFFFF, hsum=20'hFFFFF, hcarry=20'h00000, cout=0. Then a=b=20'hFFFFF, cin=1 -> out=20'hFFFFF, cout=1, hcarry=20'hFFFFF, hsum=20'h00000.
- Streaming: drive in_valid=1 for 4 consecutive cycles with a=1,2,3,4, b=10, cin=0 -> out_valid=1 for 4 consecutive cycles with out=11,12,13,14.
- Mid-stream reset: drive in_valid=1 with a=20'h12345, b=20'h11111, and assert rst asynchronously between clock edges -> all outputs go to 0 immediately, with no clock edge needed. After rst falls with in_valid=0, the outputs stay 0 and out_valid=0.

Source files
------------

// File: rtl/half_adder.sv
`default_nettype none
// ============================================================================
// Module      : half_adder
// Description : Registered WIDTH-bit ripple-carry adder built from chained
//               1-bit half-adder cells; outputs sum, carry, signed overflow
//               and the bitwise half-adder terms one cycle after in_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module half_adder #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic [WIDTH-1:0] hsum,
    output logic [WIDTH-1:0] hcarry
);

    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH:0]   w_c;
    logic             w_ovf;

    assign w_c[0] = cin;

    // Two half-adders plus an OR per bit form one full-adder stage.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign w_p[i]   = a[i] ^ b[i];
            assign w_g[i]   = a[i] & b[i];
            assign w_s[i]   = w_p[i] ^ w_c[i];
            assign w_t[i]   = w_p[i] & w_c[i];
            assign w_c[i+1] = w_g[i] | w_t[i];
        end
    endgenerate

    assign w_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];

    logic             r_valid;
    logic [WIDTH-1:0] r_out;
    logic             r_cout;
    logic             r_ovf;
    logic [WIDTH-1:0] r_hsum;
    logic [WIDTH-1:0] r_hcarry;

    // Result registers load only when in_valid is set, so idle-cycle inputs
    // (including X) never reach them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_out    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_hsum   <= '0;
            r_hcarry <= '0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_out    <= w_s;
                r_cout   <= w_c[WIDTH];
                r_ovf    <= w_ovf;
                r_hsum   <= w_p;
                r_hcarry <= w_g;
            end
        end
    end

    assign out_valid = r_valid;
    assign out       = r_out;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign hsum      = r_hsum;
    assign hcarry    = r_hcarry;

endmodule
`default_nettype wire

// File: tb/tb_half_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_half_adder
// Description : Self-checking bench for half_adder: directed vector table,
//               streaming and async-reset sequences, randomized model check.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_half_adder;

    localparam int WIDTH = 20;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             ovf;
    logic [WIDTH-1:0] hsum;
    logic [WIDTH-1:0] hcarry;

    int n_cmp = 0;
    int n_err = 0;

    half_adder #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out      (out),
        .cout     (cout),
        .ovf      (ovf),
        .hsum     (hsum),
        .hcarry   (hcarry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] e_out;
        logic             e_cout;
        logic             e_ovf;
        logic [WIDTH-1:0] e_hsum;
        logic [WIDTH-1:0] e_hcarry;
    } vec_t;

    vec_t vecs[7];

    // Expected state from plain arithmetic, updated at each modelled capture.
    logic [WIDTH-1:0] m_out, m_hsum, m_hcarry;
    logic             m_cout, m_ovf, m_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".out"},       32'(out),       32'(m_out));
        check({tag, ".cout"},      32'(cout),      32'(m_cout));
        check({tag, ".ovf"},       32'(ovf),       32'(m_ovf));
        check({tag, ".hsum"},      32'(hsum),      32'(m_hsum));
        check({tag, ".hcarry"},    32'(hcarry),    32'(m_hcarry));
    endtask

    task automatic model_capture(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                 input logic mc);
        logic [WIDTH:0] full;
        full     = {1'b0, ma} + {1'b0, mb} + (WIDTH+1)'(mc);
        m_out    = full[WIDTH-1:0];
        m_cout   = full[WIDTH];
        m_ovf    = (ma[WIDTH-1] == mb[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
        m_hsum   = ma ^ mb;
        m_hcarry = ma & mb;
        m_valid  = 1'b1;
    endtask

    task automatic model_reset();
        m_out = '0; m_cout = 1'b0; m_ovf = 1'b0;
        m_hsum = '0; m_hcarry = '0; m_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{20'h00000, 20'hFFFFF, 1'b0, 20'hFFFFF, 1'b0, 1'b0, 20'hFFFFF, 20'h00000};
        vecs[1] = '{20'h00000, 20'hFFFFF, 1'b1, 20'h00000, 1'b1, 1'b0, 20'hFFFFF, 20'h00000};
        vecs[2] = '{20'h7FFFF, 20'h00001, 1'b0, 20'h80000, 1'b0, 1'b1, 20'h7FFFE, 20'h00001};
        vecs[3] = '{20'h80000, 20'h80000, 1'b0, 20'h00000, 1'b1, 1'b1, 20'h00000, 20'h80000};
        vecs[4] = '{20'hAAAAA, 20'h55555, 1'b0, 20'hFFFFF, 1'b0, 1'b0, 20'hFFFFF, 20'h00000};
        vecs[5] = '{20'hFFFFF, 20'hFFFFF, 1'b1, 20'hFFFFF, 1'b1, 1'b0, 20'h00000, 20'hFFFFF};
        vecs[6] = '{20'h80000, 20'hFFFFF, 1'b0, 20'h7FFFF, 1'b1, 1'b1, 20'h7FFFF, 20'h80000};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed table: capture, then confirm the next idle cycle holds.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            m_valid = 1'b1;       m_out = vecs[i].e_out;   m_cout = vecs[i].e_cout;
            m_ovf = vecs[i].e_ovf; m_hsum = vecs[i].e_hsum; m_hcarry = vecs[i].e_hcarry;
            check_all($sformatf("vec%0d", i));
            @(posedge clk); #1;
            m_valid = 1'b0;
            check_all($sformatf("hold%0d", i));
        end

        // Back-to-back stream of four results with no bubbles.
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            a = WIDTH'(i); b = WIDTH'(10); cin = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
            check($sformatf("stream%0d.out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("stream%0d.out", i), 32'(out), 32'(10 + i));
        end
        @(negedge clk);
        in_valid = 1'b0;
        model_capture(WIDTH'(4), WIDTH'(10), 1'b0);

        // Randomized traffic with random valid gaps and junk on idle inputs.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            if (in_valid) model_capture(a, b, cin);
            else m_valid = 1'b0;
            check_all("rand");
        end

        // Async reset between edges clears a freshly captured result.
        @(negedge clk);
        a = 20'h12345; b = 20'h11111; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        check("midrst.pre_out", 32'(out), 32'h23456);
        check("midrst.pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("midrst.async");
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            check_all("midrst.after");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
